// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one combinational square_root unit among NUM_REQ requesters.
// One operation in flight at a time; negative (non-zero) operands bypass the unit with a NaN/error response.
module sqrt_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SQRT_LAT = 1,
  parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  resp_err,
  output logic [31:0]           sqrt_inputA,
  output logic [31:0]           sqrt_inputB,
  input  logic [31:0]           sqrt_out
);

  localparam int unsigned CNT_W = $clog2(SQRT_LAT + 1);
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]      operand_q, operand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic             resp_err_q, resp_err_d;

  logic [31:0]      req_word [NUM_REQ];
  logic             grant_found;
  logic [ID_W-1:0]  grant;
  logic [31:0]      grant_word;
  logic             grant_neg;

  // Split the flat operand bus into per-requester words
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign req_word[g] = req_data[32*g +: 32];
  end

  // Round-robin search starting at rr_ptr
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant       = idx[ID_W-1:0];
      end
    end
    grant_word = req_word[grant];
    grant_neg  = grant_word[31] & (|grant_word[30:0]);
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    operand_d    = operand_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant] = 1'b1;
          resp_id_d        = grant;
          if (grant_neg) begin
            // Negative operand: answer immediately, leave the unit's input untouched
            resp_data_d  = QNAN;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            operand_d = grant_word;
            cnt_d     = CNT_W'(SQRT_LAT);
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          resp_data_d  = sqrt_out;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
          if (32'(resp_id_q) == NUM_REQ - 1) rr_ptr_d = '0;
          else                               rr_ptr_d = resp_id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      operand_q    <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      operand_q    <= operand_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_id     = resp_id_q;
  assign resp_err    = resp_err_q;
  assign sqrt_inputA = operand_q;
  assign sqrt_inputB = '0;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter: directed scenarios, randomized traffic, and a SQRT_LAT=3 reset case.
module tb_sqrt_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned LAT  = 1;
  localparam int unsigned LAT3 = 3;
  localparam int unsigned IW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with SQRT_LAT=1
  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*32-1:0] req_data;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_data, sqrt_inputA, sqrt_inputB, sqrt_out;
  logic [IW-1:0] resp_id;

  // DUT with SQRT_LAT=3
  logic          rst3;
  logic [N-1:0]  req_valid3, req_ready3;
  logic [N*32-1:0] req_data3;
  logic          resp_valid3, resp_ready3, resp_err3;
  logic [31:0]   resp_data3, sqrt_inputA3, sqrt_inputB3, sqrt_out3;
  logic [IW-1:0] resp_id3;

  sqrt_arbiter #(.NUM_REQ(N), .SQRT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .resp_err(resp_err), .sqrt_inputA(sqrt_inputA), .sqrt_inputB(sqrt_inputB), .sqrt_out(sqrt_out));

  sqrt_arbiter #(.NUM_REQ(N), .SQRT_LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3), .resp_id(resp_id3),
    .resp_err(resp_err3), .sqrt_inputA(sqrt_inputA3), .sqrt_inputB(sqrt_inputB3), .sqrt_out(sqrt_out3));

  // IEEE-754 single <-> real helpers (normal numbers; zero/denormal read as 0)
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    m = m * (2.0 ** e);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real m;
    int  e;
    int  f;
    if (!(r > 0.0)) return 32'h0;
    m = r;
    e = 0;
    for (int i = 0; i < 300 && m >= 2.0; i++) begin m = m / 2.0; e++; end
    for (int i = 0; i < 300 && m < 1.0; i++) begin m = m * 2.0; e--; end
    f = $rtoi((m - 1.0) * 8388608.0 + 0.5);
    if (f >= 8388608) begin f = 0; e++; end
    return {1'b0, 8'(e + 127), 23'(f)};
  endfunction

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  // Behavioural square_root units
  assign sqrt_out  = r2f($sqrt(f2r(sqrt_inputA)));
  assign sqrt_out3 = r2f($sqrt(f2r(sqrt_inputA3)));

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // First valid requester searching from p upward, wrapping modulo N
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Scoreboard state
  int          q_id[$];
  logic [31:0] q_op[$];
  int          q_acc[$];
  int          acc_ids[$];
  int          acc_cycs[$];
  int          ptr     = 0;
  bit          busy    = 1'b0;
  bit          holding = 1'b0;
  logic [31:0] h_data;
  int          h_id;
  bit          h_err;
  logic [N-1:0] acc_mask = '0;

  // Monitor: predicts grants from the model pointer and checks responses against queued expectations
  always @(negedge clk) begin : mon
    int g;
    int lat;
    int id;
    logic [31:0] op;
    logic [N-1:0] exp_rdy;
    bit e_err;
    bit exp_rv;
    bit release_now;
    real ev;
    cyc++;
    release_now = 1'b0;
    if (rst) begin
      acc_mask = '0;
      busy     = 1'b0;
      holding  = 1'b0;
      ptr      = 0;
      q_id.delete(); q_op.delete(); q_acc.delete();
    end else begin
      acc_mask = req_valid & req_ready;
      // response side
      if (holding) begin
        chk("resp_hold", resp_valid && resp_data == h_data && int'(resp_id) == h_id && resp_err == h_err,
            64'({resp_valid, resp_id, resp_err, resp_data}), 64'({1'b1, IW'(h_id), h_err, h_data}));
      end else if (q_id.size() > 0) begin
        op     = q_op[0];
        e_err  = op[31] && (op[30:0] != 31'd0);
        lat    = e_err ? 1 : 1 + LAT;
        exp_rv = (cyc - q_acc[0]) >= lat;
        chk("resp_valid_timing", resp_valid == exp_rv, 64'(resp_valid), 64'(exp_rv));
        if (resp_valid) begin
          id = q_id.pop_front();
          void'(q_op.pop_front());
          void'(q_acc.pop_front());
          chk("resp_id", int'(resp_id) == id, 64'(resp_id), 64'(id));
          chk("resp_err", resp_err == e_err, 64'(resp_err), 64'(e_err));
          if (e_err) begin
            chk("resp_nan", resp_data == 32'h7FC0_0000, 64'(resp_data), 64'h7FC0_0000);
          end else begin
            ev = op[31] ? 0.0 : $sqrt(f2r(op));
            chk("resp_value", rabs(f2r(resp_data) - ev) <= 0.001 * ((ev > 1.0) ? ev : 1.0),
                64'(resp_data), 64'(r2f(ev)));
          end
          h_data  = resp_data;
          h_id    = id;
          h_err   = e_err;
          holding = 1'b1;
        end
      end else begin
        chk("resp_valid_idle", resp_valid == 1'b0, 64'(resp_valid), 64'h0);
      end
      if (holding && resp_valid && resp_ready) begin
        holding     = 1'b0;
        release_now = 1'b1;
      end
      // request side
      g       = busy ? -1 : model_grant(req_valid, ptr);
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", req_ready == exp_rdy, 64'(req_ready), 64'(exp_rdy));
      if (g >= 0) begin
        q_id.push_back(g);
        q_op.push_back(req_data[32*g +: 32]);
        q_acc.push_back(cyc);
        acc_ids.push_back(g);
        acc_cycs.push_back(cyc);
        busy = 1'b1;
      end
      if (release_now) begin
        busy = 1'b0;
        ptr  = (h_id + 1) % N;
      end
    end
  end

  // Advance one cycle and drop requests that were just accepted
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic set_req(input int i, input logic [31:0] d);
    req_data[32*i +: 32] = d;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((req_valid != '0 || busy || q_id.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done"}, n < budget, 64'(n), 64'(budget));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_f32();
    int unsigned r;
    logic [31:0] w;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0000_0000;
    if (r == 1) return 32'h8000_0000;
    w        = $urandom;
    w[30:23] = 8'($urandom_range(100, 154));
    if (r > 3) w[31] = 1'b0;
    return w;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] a0;
    int n;
    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b1;
    rst3 = 1'b1; req_valid3 = '0; req_data3 = '0; resp_ready3 = 1'b1;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid == 1'b0, 64'(resp_valid), 64'h0);
    chk("rst_resp_data", resp_data == 32'h0, 64'(resp_data), 64'h0);
    chk("rst_resp_id", resp_id == '0, 64'(resp_id), 64'h0);
    chk("rst_resp_err", resp_err == 1'b0, 64'(resp_err), 64'h0);
    chk("rst_inputA", sqrt_inputA == 32'h0, 64'(sqrt_inputA), 64'h0);
    chk("inputB_zero", sqrt_inputB == 32'h0, 64'(sqrt_inputB), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single op: 4.0 on requester 0
    set_req(0, 32'h4080_0000);
    wait_idle(20, "t1");

    // All four at once from a fresh pointer: order 0..3, accepts LAT+2 apart
    do_reset();
    acc_ids.delete(); acc_cycs.delete();
    set_req(0, 32'h4080_0000); set_req(1, 32'h42C8_0000);
    set_req(2, 32'h4110_0000); set_req(3, 32'h4120_0000);
    wait_idle(60, "t2");
    chk("t2_count", acc_ids.size() == 4, 64'(acc_ids.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc_ids.size(); i++) begin
      chk("t2_order", acc_ids[i] == i, 64'(acc_ids[i]), 64'(i));
      if (i > 0) chk("t2_spacing", acc_cycs[i] - acc_cycs[i-1] == LAT + 2,
                     64'(acc_cycs[i] - acc_cycs[i-1]), 64'(LAT + 2));
    end

    // Wrap: grant 3, then 0 and 3 together -> 0 then 3
    acc_ids.delete();
    set_req(3, 32'h41C8_0000);
    wait_idle(20, "t3a");
    set_req(0, 32'h4110_0000); set_req(3, 32'h4080_0000);
    wait_idle(40, "t3b");
    chk("t3_count", acc_ids.size() == 3, 64'(acc_ids.size()), 64'd3);
    if (acc_ids.size() == 3) begin
      chk("t3_first", acc_ids[0] == 3, 64'(acc_ids[0]), 64'd3);
      chk("t3_second", acc_ids[1] == 0, 64'(acc_ids[1]), 64'd0);
      chk("t3_third", acc_ids[2] == 3, 64'(acc_ids[2]), 64'd3);
    end

    // Backpressure with a competing requester pending
    resp_ready = 1'b0;
    set_req(1, 32'h4110_0000);
    n = 0;
    while (!resp_valid && n < 10) begin tick(); n++; end
    chk("t4_resp_seen", resp_valid == 1'b1, 64'(resp_valid), 64'h1);
    set_req(2, 32'h4180_0000);
    repeat (5) tick();
    resp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_release", resp_valid == 1'b0, 64'(resp_valid), 64'h0);
    wait_idle(20, "t4");

    // Negative operand bypasses the unit; zeros of both signs go through it
    a0 = sqrt_inputA;
    set_req(2, 32'hC080_0000);
    wait_idle(20, "t5");
    chk("t5_inputA_held", sqrt_inputA == a0, 64'(sqrt_inputA), 64'(a0));
    set_req(0, 32'h8000_0000);
    wait_idle(20, "t5_negzero");
    set_req(1, 32'h0000_0000);
    wait_idle(20, "t5_poszero");

    // Randomized traffic with random backpressure
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_data[32*i +: 32] = rand_f32();
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    wait_idle(40, "rand");

    // SQRT_LAT=3: reset in the second WAIT cycle discards the op
    @(posedge clk);
    #1 rst3 = 1'b0;
    req_valid3 = 4'b0001;
    req_data3[31:0] = 32'h4180_0000;
    @(negedge clk);
    chk("t6_grant0", req_ready3 == 4'b0001, 64'(req_ready3), 64'h1);
    @(posedge clk);
    #1 req_valid3 = '0;
    @(posedge clk);
    #1 rst3 = 1'b1;
    @(posedge clk);
    #1 rst3 = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", resp_valid3 == 1'b0, 64'(resp_valid3), 64'h0);
    chk("t6_rst_data", resp_data3 == 32'h0, 64'(resp_data3), 64'h0);
    chk("t6_rst_id", resp_id3 == '0, 64'(resp_id3), 64'h0);
    chk("t6_rst_err", resp_err3 == 1'b0, 64'(resp_err3), 64'h0);
    chk("t6_rst_ready", req_ready3 == '0, 64'(req_ready3), 64'h0);
    chk("t6_rst_inputA", sqrt_inputA3 == 32'h0, 64'(sqrt_inputA3), 64'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_resp", resp_valid3 == 1'b0, 64'(resp_valid3), 64'h0);
    end
    @(posedge clk);
    #1;
    req_valid3 = 4'b0100;
    req_data3[64 +: 32] = 32'h4010_0000;
    @(negedge clk);
    chk("t6_grant2", req_ready3 == 4'b0100, 64'(req_ready3), 64'h4);
    @(posedge clk);
    #1 req_valid3 = '0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid3) break;
    end
    chk("t6_latency", n == 1 + LAT3, 64'(n), 64'(1 + LAT3));
    chk("t6_id", resp_id3 == IW'(2), 64'(resp_id3), 64'h2);
    chk("t6_err", resp_err3 == 1'b0, 64'(resp_err3), 64'h0);
    chk("t6_value", rabs(f2r(resp_data3) - 1.5) <= 0.001, 64'(resp_data3), 64'h3FC0_0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
Shares one combinational `square_root` unit among NUM_REQ requesters. Requesters use a valid/ready handshake. A round-robin grant pointer selects the next requester, and the block holds the chosen operand on the unit's input for SQRT_LAT cycles. It then registers the result and returns it to a single response port, tagged with the requester ID. It sits between the TPU lane controllers and the shared `square_root` datapath. Only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- SQRT_LAT, 1, cycles the operand is held on `sqrt_inputA` before `sqrt_out` is sampled (1..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*32  per-requester IEEE-754 single-precision operand; requester i uses bits [32i+31:32i].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  IEEE-754 result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_err  out  1  set when the operand was negative (excluding -0).
- sqrt_inputA  out  32  drives `square_root.inputA`.
- sqrt_inputB  out  32  drives `square_root.inputB`; constant 32'h0.
- sqrt_out  in  32  from `square_root.out`.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, operand register=0, counter=0.
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0, req_ready=0.
  - Reset mid-operation discards the in-flight op with no response.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[grant] is driven combinationally high in the same cycle; the handshake completes on that edge.
  - The edge captures operand ← req_data[grant] and id ← grant.
  - If operand[31]=1 and operand[30:0]≠0: go to RESP with resp_data=32'h7FC00000 and resp_err=1. The unit is not used.
  - Otherwise: go to WAIT with counter=SQRT_LAT.
  - With no req_valid, stay in IDLE.
- WAIT:
  - sqrt_inputA = operand register. It is held at all times, equal to 0 after reset.
  - The counter decrements each cycle.
  - On the edge where counter==1: resp_data ← sqrt_out, resp_err ← 0, go to RESP.
- RESP:
  - resp_valid=1; resp_data, resp_id and resp_err are stable until the handshake.
  - All req_ready=0.
  - On resp_valid & resp_ready: go to IDLE, rr_ptr ← (id+1) mod NUM_REQ, resp_valid deasserts next cycle.
- Latency: accept edge at cycle t → resp_valid high from cycle t+1+SQRT_LAT. The negative-operand path responds in cycle t+1.
- Throughput: at most one accept per SQRT_LAT+2 cycles, since accepts occur only in IDLE.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 other grants.
- A requester deasserting req_valid while not granted is legal and has no effect.
- Zero operands:
  - -0 (32'h80000000) passes through the unit with no error.
  - +0 gives the unit's result for 0.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Only rr_ptr advances on response completion, not on accept. A reset between accept and response leaves rr_ptr=0.

Test Plan:
1. Single op, SQRT_LAT=1: req_valid[0]=1 with 32'h40800000 (4.0) → req_ready[0] high for one cycle; 2 cycles later resp_valid=1, resp_data=32'h40000000 (2.0, within 0.001), resp_id=0, resp_err=0.
2. All four requesters valid simultaneously with 4.0, 100.0, 9.0, 10.0, resp_ready=1 → responses in order id 0,1,2,3 with 2.0, 10.0, 3.0, 3.16228; each accept is 3 cycles apart.
3. Round-robin after wrap: first grant id 3, then requesters 0 and 3 both valid → next grant id 0, then id 3.
4. Backpressure: resp_ready=0 for 5 cycles in RESP → resp_valid, resp_data and resp_id stable; all req_ready=0. On release, completes in one cycle and returns to IDLE.
5. Negative operand 32'hC0800000 (-4.0) → response next cycle with resp_data=32'h7FC00000 and resp_err=1; sqrt_inputA unchanged.
6. With SQRT_LAT=3, assert rst in the second WAIT cycle → all outputs 0 next cycle, rr_ptr=0, no response; the next request from id 2 is granted and answered 4 cycles after accept.
